// File: rtl/unidade_busca_pkg.sv
// rtl/unidade_busca_pkg.sv - shared types and constants for the instruction fetch unit
package unidade_busca_pkg;

   localparam int LARGURA_INSTR = 32;

   localparam logic [LARGURA_INSTR-1:0] NOP = 32'h0000_0000;

   typedef enum logic [1:0] {
      BUSCA  = 2'd0,
      PARADO = 2'd1,
      ERRO   = 2'd2
   } estado_t;

endpackage

// File: rtl/unidade_busca_if.sv
// rtl/unidade_busca_if.sv - memory, redirect and decode handshake bundle of the fetch unit
interface unidade_busca_if;
   import unidade_busca_pkg::*;

   logic [31:0]              endereco;
   logic [LARGURA_INSTR-1:0] instrucao_mem;
   logic                     desvio_valido;
   logic [31:0]              desvio_alvo;
   logic                     saida_pronta;
   logic                     saida_valida;
   logic [LARGURA_INSTR-1:0] instrucao_saida;
   logic [31:0]              pc_saida;

   modport master (
      output endereco,
      input  instrucao_mem,
      input  desvio_valido,
      input  desvio_alvo,
      input  saida_pronta,
      output saida_valida,
      output instrucao_saida,
      output pc_saida
   );

   modport slave (
      input  endereco,
      output instrucao_mem,
      output desvio_valido,
      output desvio_alvo,
      output saida_pronta,
      input  saida_valida,
      input  instrucao_saida,
      input  pc_saida
   );

endinterface

// File: rtl/unidade_busca_registro_if_id.sv
// rtl/unidade_busca_registro_if_id.sv - IF/ID output register with valid bit, flush and stall
module registro_if_id
   import unidade_busca_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     carrega,
   input  logic                     pronta,
   input  logic [LARGURA_INSTR-1:0] instrucao_nova,
   input  logic [31:0]              pc_novo,
   output logic                     valida,
   output logic [LARGURA_INSTR-1:0] instrucao,
   output logic [31:0]              pc
);

   // Flush wins; a new word replaces the old one; otherwise a consumed word drops its valid bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valida    <= 1'b0;
         instrucao <= '0;
         pc        <= '0;
      end else if (flush) begin
         valida <= 1'b0;
      end else if (carrega) begin
         valida    <= 1'b1;
         instrucao <= instrucao_nova;
         pc        <= pc_novo;
      end else if (pronta) begin
         valida <= 1'b0;
      end
   end

endmodule

// File: rtl/unidade_busca.sv
// rtl/unidade_busca.sv - instruction fetch unit: pc, halt/error state machine and delivery counter
module unidade_busca
   import unidade_busca_pkg::*;
#(
   parameter logic [31:0] PC_INICIAL   = 32'h0000_0000,
   parameter logic [31:0] ENDERECO_MAX = 32'h0000_03FC
)(
   input  logic                 clk,
   input  logic                 rst_n,
   unidade_busca_if.master      bus,
   output logic                 fim_programa,
   output logic                 erro_endereco,
   output logic [15:0]          contador_busca
);

   estado_t                  estado, estado_prox;
   logic [31:0]              pc, pc_prox;
   logic                     valida;
   logic [LARGURA_INSTR-1:0] instrucao;
   logic [31:0]              pc_reg;
   logic                     redireciona, alvo_invalido, oportunidade, estouro;
   logic                     captura, handshake;

   assign redireciona   = bus.desvio_valido && (estado != ERRO);
   assign alvo_invalido = (bus.desvio_alvo[1:0] != 2'b00) || (bus.desvio_alvo > ENDERECO_MAX);
   assign oportunidade  = (estado == BUSCA) && (!valida || bus.saida_pronta) && !bus.desvio_valido;
   assign estouro       = pc > ENDERECO_MAX;
   assign captura       = oportunidade && !estouro && (bus.instrucao_mem != NOP);
   // A redirect discards the word on the output, so it is not counted as delivered
   assign handshake     = valida && bus.saida_pronta && !redireciona;

   assign bus.endereco        = pc;
   assign bus.saida_valida    = valida;
   assign bus.instrucao_saida = instrucao;
   assign bus.pc_saida        = pc_reg;
   assign fim_programa        = (estado == PARADO);
   assign erro_endereco       = (estado == ERRO);

   registro_if_id u_registro_if_id (
      .clk            (clk),
      .rst_n          (rst_n),
      .flush          (redireciona),
      .carrega        (captura),
      .pronta         (bus.saida_pronta),
      .instrucao_nova (bus.instrucao_mem),
      .pc_novo        (pc),
      .valida         (valida),
      .instrucao      (instrucao),
      .pc             (pc_reg)
   );

   // State and pc registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         estado <= BUSCA;
         pc     <= PC_INICIAL;
      end else begin
         estado <= estado_prox;
         pc     <= pc_prox;
      end
   end

   // Next state and pc: redirect beats capture; the halt nop and an out-of-range pc are not presented
   always_comb begin
      estado_prox = estado;
      pc_prox     = pc;
      if (redireciona) begin
         if (alvo_invalido) begin
            estado_prox = ERRO;
         end else begin
            estado_prox = BUSCA;
            pc_prox     = bus.desvio_alvo;
         end
      end else if (oportunidade) begin
         if (estouro) begin
            estado_prox = ERRO;
         end else if (bus.instrucao_mem == NOP) begin
            estado_prox = PARADO;
         end else begin
            pc_prox = pc + 32'd4;
         end
      end
   end

   // Delivered-instruction counter, saturating
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         contador_busca <= 16'd0;
      end else if (handshake && (contador_busca != 16'hFFFF)) begin
         contador_busca <= contador_busca + 16'd1;
      end
   end

endmodule

// File: tb/tb_unidade_busca.sv
// tb/tb_unidade_busca.sv - directed self-checking bench for the fetch unit
module tb_unidade_busca;

   logic        clk;
   logic        rst_n;
   logic        fim_programa;
   logic        erro_endereco;
   logic [15:0] contador_busca;
   logic [31:0] mem [0:255];
   int          testes;
   int          falhas;

   unidade_busca_if bus ();

   unidade_busca dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .bus            (bus),
      .fim_programa   (fim_programa),
      .erro_endereco  (erro_endereco),
      .contador_busca (contador_busca)
   );

   assign bus.instrucao_mem = (bus.endereco <= 32'h0000_03FC) ? mem[bus.endereco[9:2]] : 32'hDEAD_BEEF;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testes++;
      assert (obs === exp) else begin
         falhas++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] palavra(input logic [31:0] a);
      return 32'h1000_0001 + (a >> 2);
   endfunction

   initial begin
      testes = 0;
      falhas = 0;
      for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0001 + i;
      mem[11] = 32'h0000_0000;
      rst_n = 1'b0;
      bus.desvio_valido = 1'b0;
      bus.desvio_alvo   = 32'h0;
      bus.saida_pronta  = 1'b1;
      #2;
      chk("rst_valida", {31'd0, bus.saida_valida}, 32'd0);
      chk("rst_instr", bus.instrucao_saida, 32'd0);
      chk("rst_pc_saida", bus.pc_saida, 32'd0);
      chk("rst_endereco", bus.endereco, 32'd0);
      chk("rst_contador", {16'd0, contador_busca}, 32'd0);
      chk("rst_fim", {31'd0, fim_programa}, 32'd0);
      chk("rst_erro", {31'd0, erro_endereco}, 32'd0);
      rst_n = 1'b1;

      // straight-line program up to the halt nop at 0x2C
      for (int i = 0; i < 11; i++) begin
         tick();
         chk("seq_pc_saida", bus.pc_saida, 32'(4 * i));
         chk("seq_valida", {31'd0, bus.saida_valida}, 32'd1);
         chk("seq_instr", bus.instrucao_saida, palavra(32'(4 * i)));
      end
      tick();
      chk("halt_fim", {31'd0, fim_programa}, 32'd1);
      chk("halt_valida", {31'd0, bus.saida_valida}, 32'd0);
      chk("halt_contador", {16'd0, contador_busca}, 32'd11);
      chk("halt_endereco", bus.endereco, 32'h2C);
      tick();
      chk("halt_hold_endereco", bus.endereco, 32'h2C);
      chk("halt_hold_fim", {31'd0, fim_programa}, 32'd1);

      // redirect out of PARADO
      bus.desvio_valido = 1'b1;
      bus.desvio_alvo   = 32'h04;
      tick();
      bus.desvio_valido = 1'b0;
      chk("parado_desvio_fim", {31'd0, fim_programa}, 32'd0);
      chk("parado_desvio_valida", {31'd0, bus.saida_valida}, 32'd0);
      tick();
      chk("parado_desvio_pc_saida", bus.pc_saida, 32'h04);
      chk("parado_desvio_valida2", {31'd0, bus.saida_valida}, 32'd1);

      // stall at pc_saida 0x08
      tick();
      chk("pre_stall_pc_saida", bus.pc_saida, 32'h08);
      bus.saida_pronta = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_pc_saida", bus.pc_saida, 32'h08);
         chk("stall_instr", bus.instrucao_saida, palavra(32'h08));
         chk("stall_endereco", bus.endereco, 32'h0C);
         chk("stall_contador", {16'd0, contador_busca}, 32'd12);
      end
      bus.saida_pronta = 1'b1;
      tick();
      chk("post_stall_pc_saida", bus.pc_saida, 32'h0C);
      chk("post_stall_contador", {16'd0, contador_busca}, 32'd13);

      // redirect while pc=0x10 flushes the word at 0x10
      chk("pre_desvio_endereco", bus.endereco, 32'h10);
      bus.desvio_valido = 1'b1;
      bus.desvio_alvo   = 32'h20;
      tick();
      bus.desvio_valido = 1'b0;
      chk("desvio_flush_valida", {31'd0, bus.saida_valida}, 32'd0);
      chk("desvio_endereco", bus.endereco, 32'h20);
      chk("desvio_contador", {16'd0, contador_busca}, 32'd13);
      tick();
      chk("desvio_pc_saida", bus.pc_saida, 32'h20);
      chk("desvio_instr", bus.instrucao_saida, palavra(32'h20));

      // reset in the middle of a stall at pc_saida 0x14
      bus.desvio_valido = 1'b1;
      bus.desvio_alvo   = 32'h14;
      tick();
      bus.desvio_valido = 1'b0;
      tick();
      chk("pre_rst_pc_saida", bus.pc_saida, 32'h14);
      bus.saida_pronta = 1'b0;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_valida", {31'd0, bus.saida_valida}, 32'd0);
      chk("midrst_pc_saida", bus.pc_saida, 32'd0);
      chk("midrst_instr", bus.instrucao_saida, 32'd0);
      chk("midrst_endereco", bus.endereco, 32'd0);
      chk("midrst_contador", {16'd0, contador_busca}, 32'd0);
      tick();
      rst_n = 1'b1;
      bus.saida_pronta = 1'b1;
      tick();
      chk("postrst_pc_saida", bus.pc_saida, 32'h00);
      chk("postrst_valida", {31'd0, bus.saida_valida}, 32'd1);

      // misaligned redirect is fatal and sticky
      bus.desvio_valido = 1'b1;
      bus.desvio_alvo   = 32'h22;
      tick();
      chk("desal_erro", {31'd0, erro_endereco}, 32'd1);
      chk("desal_valida", {31'd0, bus.saida_valida}, 32'd0);
      chk("desal_endereco", bus.endereco, 32'h04);
      bus.desvio_alvo = 32'h08;
      tick();
      tick();
      bus.desvio_valido = 1'b0;
      chk("erro_sticky", {31'd0, erro_endereco}, 32'd1);
      chk("erro_ignora_desvio", bus.endereco, 32'h04);
      chk("erro_valida", {31'd0, bus.saida_valida}, 32'd0);
      chk("erro_contador", {16'd0, contador_busca}, 32'd0);

      // sequential overflow past the last word
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      bus.desvio_valido = 1'b1;
      bus.desvio_alvo   = 32'h3F8;
      tick();
      bus.desvio_valido = 1'b0;
      tick();
      chk("top_pc_saida0", bus.pc_saida, 32'h3F8);
      tick();
      chk("top_pc_saida1", bus.pc_saida, 32'h3FC);
      chk("top_endereco", bus.endereco, 32'h400);
      chk("top_erro_antes", {31'd0, erro_endereco}, 32'd0);
      tick();
      chk("estouro_erro", {31'd0, erro_endereco}, 32'd1);
      chk("estouro_valida", {31'd0, bus.saida_valida}, 32'd0);
      chk("estouro_contador", {16'd0, contador_busca}, 32'd2);

      // redirect beyond the top of memory
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      tick();
      bus.desvio_valido = 1'b1;
      bus.desvio_alvo   = 32'h400;
      tick();
      bus.desvio_valido = 1'b0;
      chk("alvo_max_erro", {31'd0, erro_endereco}, 32'd1);
      chk("alvo_max_endereco", bus.endereco, 32'h04);

      $display("[TB] %0d tests run, %0d failed", testes, falhas);
      $finish;
   end

endmodule
